// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline controller. Tracks NSTAGE post-issue stages,
// derives per-stage enables from hold requests, selects forwarding sources,
// interlocks on late results, blocks issue after redirects and keeps
// retire/stall performance counters.
module pipe_ctrl #(
    parameter int NSTAGE     = 4,
    parameter int REGW       = 5,
    parameter int LATE_STAGE = 2,
    parameter int REDIR_LAT  = 1,
    parameter int CNT_W      = 64,
    localparam int FW        = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REGW-1:0]   in_rs1,
    input  logic [REGW-1:0]   in_rs2,
    input  logic [REGW-1:0]   in_rd,
    input  logic              in_wen,
    input  logic              in_late,
    input  logic [NSTAGE-1:0] hold,
    input  logic              redirect,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [NSTAGE-1:0] stage_en,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int RCW = (REDIR_LAT > 0) ? $clog2(REDIR_LAT + 1) : 1;

    // Per-stage tracking state
    logic [NSTAGE-1:0] valid_q, valid_d;
    logic [NSTAGE-1:0] wen_q,   wen_d;
    logic [NSTAGE-1:0] late_q,  late_d;
    logic [REGW-1:0]   rd_q [NSTAGE];
    logic [REGW-1:0]   rd_d [NSTAGE];

    logic [RCW-1:0]    redir_cnt_q, redir_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NSTAGE-1:0] freeze;
    logic              interlock;
    logic              issue;

    // Freeze propagates from a held stage back to every lower-index stage
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            acc = acc | hold[NSTAGE-1-i];
            freeze[NSTAGE-1-i] = acc;
        end
    end

    // Forwarding select and late-result interlock; scanning from the highest
    // stage down leaves the youngest (smallest index) match in the output
    always_comb begin
        fwd_a     = '0;
        fwd_b     = '0;
        interlock = 1'b0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            int j;
            j = NSTAGE - 1 - int'(i);
            if ((in_rs1 != '0) && valid_q[j] && wen_q[j] && (rd_q[j] == in_rs1)) begin
                fwd_a = FW'(j + 1);
                if (late_q[j] && (j < LATE_STAGE)) interlock = 1'b1;
            end
            if ((in_rs2 != '0) && valid_q[j] && wen_q[j] && (rd_q[j] == in_rs2)) begin
                fwd_b = FW'(j + 1);
                if (late_q[j] && (j < LATE_STAGE)) interlock = 1'b1;
            end
        end
    end

    assign in_ready = !freeze[0] && !interlock && !redirect && (redir_cnt_q == '0);
    assign issue    = in_valid && in_ready;

    // Stage advance: enabled stages take the previous stage or a bubble
    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        late_d  = late_q;
        rd_d    = rd_q;
        if (!freeze[0]) begin
            valid_d[0] = issue;
            wen_d[0]   = issue && in_wen;
            late_d[0]  = issue && in_late;
            rd_d[0]    = issue ? in_rd : '0;
        end
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            if (!freeze[k]) begin
                if (!freeze[k-1]) begin
                    valid_d[k] = valid_q[k-1];
                    wen_d[k]   = wen_q[k-1];
                    late_d[k]  = late_q[k-1];
                    rd_d[k]    = rd_q[k-1];
                end else begin
                    valid_d[k] = 1'b0;
                    wen_d[k]   = 1'b0;
                    late_d[k]  = 1'b0;
                    rd_d[k]    = '0;
                end
            end
        end
    end

    // Redirect blocks issue for REDIR_LAT further cycles; ignored while stage 0 is frozen
    always_comb begin
        redir_cnt_d = redir_cnt_q;
        if (redirect && !freeze[0]) begin
            redir_cnt_d = RCW'(REDIR_LAT);
        end else if (redir_cnt_q != '0) begin
            redir_cnt_d = redir_cnt_q - RCW'(1);
        end
    end

    // Performance counters, wrapping naturally at CNT_W bits
    always_comb begin
        retire_cnt_d = retire_cnt_q + CNT_W'(retire);
        stall_cnt_d  = stall_cnt_q + CNT_W'(in_valid && !in_ready);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            wen_q        <= '0;
            late_q       <= '0;
            for (int unsigned k = 0; k < NSTAGE; k++) rd_q[k] <= '0;
            redir_cnt_q  <= '0;
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            wen_q        <= wen_d;
            late_q       <= late_d;
            rd_q         <= rd_d;
            redir_cnt_q  <= redir_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign stage_en    = ~freeze;
    assign retire      = valid_q[NSTAGE-1] && !freeze[NSTAGE-1];
    assign retire_cnt  = retire_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios; expectations are queued at stimulus time
// and a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wen, in_late;
    logic [3:0]  hold;
    logic        redirect;
    logic [3:0]  stage_valid, stage_en;
    logic [2:0]  fwd_a, fwd_b;
    logic        retire;
    logic [63:0] retire_cnt, stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NSTAGE(4), .REGW(5), .LATE_STAGE(2), .REDIR_LAT(1), .CNT_W(64)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
        .in_late(in_late), .hold(hold), .redirect(redirect),
        .stage_valid(stage_valid), .stage_en(stage_en), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .retire(retire), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt)
    );

    typedef enum int {K_READY, K_FWDA, K_FWDB, K_SVALID, K_SEN, K_RETCNT, K_STALLCNT, K_RETIRE} kind_e;
    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   ret_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input kind_e k, input logic [63:0] v, input string nm);
        exp_t e;
        int   i;
        e.cyc = c; e.kind = k; e.val = v; e.name = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [63:0] observe(input kind_e k);
        case (k)
            K_READY:    return 64'(in_ready);
            K_FWDA:     return 64'(fwd_a);
            K_FWDB:     return 64'(fwd_b);
            K_SVALID:   return 64'(stage_valid);
            K_SEN:      return 64'(stage_en);
            K_RETCNT:   return retire_cnt;
            K_STALLCNT: return stall_cnt;
            K_RETIRE:   return 64'(retire);
            default:    return '0;
        endcase
    endfunction

    // Monitor: retire pulses pop the retire queue; scheduled observations pop the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   c;
        logic [63:0] got;
        if (retire === 1'b1) begin
            checks++;
            if (ret_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected cycle %0d got retire=1 expected none", cyc);
            end else begin
                c = ret_q.pop_front();
                if (c != cyc) begin
                    errors++;
                    $display("FAIL retire_time got cycle %0d expected cycle %0d", cyc, c);
                end
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            got = observe(e.kind);
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s missed cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d got %0h expected %0h", e.name, cyc, got, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic late);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen; in_late = late;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic idle_until(input int c);
        idle();
        while (cyc < c) step();
    endtask

    initial begin
        int b;
        reset = 1'b1; hold = '0; redirect = 1'b0;
        idle();
        step();
        step();

        // Reset state
        reset = 1'b0;
        b = cyc;
        expect_at(b, K_SVALID, 64'h0, "rst_svalid");
        expect_at(b, K_SEN, 64'hF, "rst_sen");
        expect_at(b, K_READY, 64'h1, "rst_ready");
        expect_at(b, K_FWDA, 64'h0, "rst_fwda");
        expect_at(b, K_FWDB, 64'h0, "rst_fwdb");
        expect_at(b, K_RETIRE, 64'h0, "rst_retire");
        expect_at(b, K_RETCNT, 64'h0, "rst_retcnt");
        expect_at(b, K_STALLCNT, 64'h0, "rst_stallcnt");
        idle_until(b + 2);

        // Four independent issues, retire NSTAGE cycles later
        b = cyc;
        for (int i = 0; i < 4; i++) begin
            expect_at(b + i, K_READY, 64'h1, "a_ready");
            ret_q.push_back(b + 4 + i);
        end
        expect_at(b + 8, K_RETCNT, 64'd4, "a_retcnt");
        expect_at(b + 8, K_STALLCNT, 64'd0, "a_stallcnt");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'(i + 1), 1'b1, 1'b0);
            step();
        end
        idle_until(b + 9);

        // Late load then dependent consumer: two interlock cycles
        b = cyc;
        expect_at(b, K_READY, 64'h1, "b_ready_ld");
        expect_at(b + 1, K_READY, 64'h0, "b_ready_il0");
        expect_at(b + 1, K_FWDA, 64'd1, "b_fwda_s0");
        expect_at(b + 2, K_READY, 64'h0, "b_ready_il1");
        expect_at(b + 2, K_FWDA, 64'd2, "b_fwda_s1");
        expect_at(b + 3, K_READY, 64'h1, "b_ready_go");
        expect_at(b + 3, K_FWDA, 64'd3, "b_fwda_s2");
        expect_at(b + 4, K_STALLCNT, 64'd2, "b_stallcnt");
        expect_at(b + 8, K_RETCNT, 64'd6, "b_retcnt");
        ret_q.push_back(b + 4);
        ret_q.push_back(b + 7);
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
            step();
        end
        idle_until(b + 9);

        // ALU forwarding with youngest-match priority
        b = cyc;
        expect_at(b, K_READY, 64'h1, "c_ready0");
        expect_at(b + 1, K_READY, 64'h1, "c_ready1");
        expect_at(b + 1, K_FWDB, 64'd1, "c_fwdb_s0");
        expect_at(b + 1, K_FWDA, 64'd0, "c_fwda_rf");
        expect_at(b + 2, K_FWDA, 64'd1, "c_fwda_youngest");
        expect_at(b + 2, K_FWDB, 64'd1, "c_fwdb_youngest");
        expect_at(b + 2, K_READY, 64'h1, "c_ready2");
        expect_at(b + 3, K_FWDA, 64'd2, "c_fwda_s1");
        expect_at(b + 3, K_FWDB, 64'd0, "c_fwdb_rf");
        expect_at(b + 8, K_RETCNT, 64'd10, "c_retcnt");
        expect_at(b + 8, K_STALLCNT, 64'd2, "c_stallcnt");
        for (int i = 0; i < 4; i++) ret_q.push_back(b + 4 + i);
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
        drive(1'b1, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0); step();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); step();
        idle_until(b + 9);

        // Full pipe, hold on stage 2 for three cycles
        b = cyc;
        for (int i = 0; i < 4; i++) expect_at(b + i, K_READY, 64'h1, "d_ready_fill");
        expect_at(b + 4, K_SVALID, 64'hF, "d_svalid_full");
        for (int i = 4; i < 7; i++) begin
            expect_at(b + i, K_SEN, 64'h8, "d_sen_hold");
            expect_at(b + i, K_READY, 64'h0, "d_ready_hold");
        end
        expect_at(b + 5, K_SVALID, 64'h7, "d_svalid_bubble");
        expect_at(b + 6, K_SVALID, 64'h7, "d_svalid_bubble2");
        expect_at(b + 7, K_SEN, 64'hF, "d_sen_release");
        expect_at(b + 7, K_SVALID, 64'h7, "d_svalid_release");
        expect_at(b + 7, K_READY, 64'h1, "d_ready_release");
        expect_at(b + 8, K_SVALID, 64'hE, "d_svalid_shift");
        expect_at(b + 11, K_RETCNT, 64'd14, "d_retcnt");
        ret_q.push_back(b + 4);
        ret_q.push_back(b + 8);
        ret_q.push_back(b + 9);
        ret_q.push_back(b + 10);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'(10 + i), 1'b1, 1'b0);
            step();
        end
        idle();
        hold = 4'b0100;
        step(); step(); step();
        hold = 4'b0000;
        idle_until(b + 12);

        // Redirect blocks issue for two cycles, pipeline unaffected
        b = cyc;
        expect_at(b, K_READY, 64'h1, "e_ready0");
        expect_at(b + 1, K_READY, 64'h0, "e_ready_redir");
        expect_at(b + 1, K_SVALID, 64'h1, "e_svalid1");
        expect_at(b + 2, K_READY, 64'h0, "e_ready_lat");
        expect_at(b + 2, K_SVALID, 64'h2, "e_svalid2");
        expect_at(b + 3, K_READY, 64'h1, "e_ready_back");
        expect_at(b + 3, K_SVALID, 64'h4, "e_svalid3");
        expect_at(b + 4, K_SVALID, 64'h9, "e_svalid4");
        expect_at(b + 4, K_STALLCNT, 64'd4, "e_stallcnt");
        expect_at(b + 8, K_RETCNT, 64'd16, "e_retcnt");
        ret_q.push_back(b + 4);
        ret_q.push_back(b + 7);
        drive(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0); step();
        redirect = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0); step();
        redirect = 1'b0;
        step(); step();
        idle_until(b + 9);

        // rd=0 late producer never interlocks; then reset mid-stream
        b = cyc;
        expect_at(b, K_READY, 64'h1, "f_ready0");
        expect_at(b + 1, K_READY, 64'h1, "f_ready_x0");
        expect_at(b + 1, K_FWDA, 64'd0, "f_fwda_x0");
        expect_at(b + 1, K_FWDB, 64'd0, "f_fwdb_x0");
        expect_at(b + 5, K_RETCNT, 64'd17, "f_retcnt_pre");
        expect_at(b + 5, K_STALLCNT, 64'd4, "f_stallcnt_pre");
        expect_at(b + 6, K_SVALID, 64'h0, "f_svalid_post");
        expect_at(b + 6, K_RETIRE, 64'h0, "f_retire_post");
        expect_at(b + 6, K_RETCNT, 64'd0, "f_retcnt_post");
        expect_at(b + 6, K_STALLCNT, 64'd0, "f_stallcnt_post");
        expect_at(b + 6, K_READY, 64'h1, "f_ready_post");
        ret_q.push_back(b + 4);
        ret_q.push_back(b + 5);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); step();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'(1 + i), 1'b1, 1'b0);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_until(b + 12);

        while (ret_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL retire_missing expected cycle %0d got no retire", ret_q.pop_front());
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked cycle %0d expected %0h", e.name, e.cyc, e.val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
